main_control_fsm: RTL

Multicycle control unit of the RV32I core. It decodes the instruction register contents and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath select and write enable. It also produces `Imm_Src_o`, which selects the immediate format for the downstream immediate extend unit.

---
 rtl/main_control_fsm.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/main_control_fsm.sv
// Multicycle RV32I control unit: walks each instruction through its state sequence and
// drives every datapath select, write enable and the immediate-format select.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_S = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_J = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;
endpackage

module main_control_fsm
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] Instr_i,
  input  logic            Zero_i,
  input  logic            Mem_Ready_i,
  output logic            Mem_Req_o,
  output logic            Mem_Write_o,
  output logic            Adr_Src_o,
  output logic            IR_Write_o,
  output logic            PC_Write_o,
  output logic            Reg_Write_o,
  output logic [1:0]      Result_Src_o,
  output logic [1:0]      ALU_Src_A_o,
  output logic [1:0]      ALU_Src_B_o,
  output logic [2:0]      ALU_Control_o,
  output logic [2:0]      Imm_Src_o,
  output logic            Illegal_o
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_AUIPC
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode            = Instr_i[6:0];
  assign funct3            = Instr_i[14:12];
  assign funct7            = Instr_i[31:25];
  assign unused_instr_bits = ^{Instr_i[24:15], Instr_i[11:7]};

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  alu_decode = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = ALU_AND;
      3'b110:  alu_decode = ALU_OR;
      3'b100:  alu_decode = ALU_XOR;
      3'b010:  alu_decode = ALU_SLT;
      3'b001:  alu_decode = ALU_SLL;
      3'b101:  alu_decode = ALU_SRL;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  // Shifts only exist in their logical form; arithmetic right shifts are rejected.
  function automatic logic funct_legal(input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b011:         funct_legal = 1'b0;
      3'b001, 3'b101: funct_legal = (f7 == 7'b0000000);
      default:        funct_legal = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    Mem_Req_o     = 1'b0;
    Mem_Write_o   = 1'b0;
    Adr_Src_o     = 1'b0;
    IR_Write_o    = 1'b0;
    PC_Write_o    = 1'b0;
    Reg_Write_o   = 1'b0;
    Result_Src_o  = RES_ALUOUT;
    ALU_Src_A_o   = SRCA_PC;
    ALU_Src_B_o   = SRCB_RS2;
    ALU_Control_o = ALU_ADD;
    Illegal_o     = 1'b0;

    case (opcode)
      OP_LOAD, OP_I:    Imm_Src_o = EXT_I;
      OP_STORE:         Imm_Src_o = EXT_S;
      OP_BR:            Imm_Src_o = EXT_B;
      OP_JAL:           Imm_Src_o = EXT_J;
      OP_LUI, OP_AUIPC: Imm_Src_o = EXT_U;
      default:          Imm_Src_o = 3'b000;
    endcase

    case (state_q)
      S_FETCH: begin
        Mem_Req_o    = 1'b1;
        ALU_Src_B_o  = SRCB_FOUR;
        Result_Src_o = RES_ALU;
        if (Mem_Ready_i) begin
          IR_Write_o = 1'b1;
          PC_Write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALU_Src_A_o = SRCA_OLDPC;
        ALU_Src_B_o = SRCB_IMM;
        Illegal_o   = 1'b1;
        state_d     = S_FETCH;
        case (opcode)
          OP_LOAD, OP_STORE:
            if (funct3 == 3'b010) begin Illegal_o = 1'b0; state_d = S_MEMADR; end
          OP_R:
            if (funct_legal(funct3, funct7)) begin Illegal_o = 1'b0; state_d = S_EXECR; end
          OP_I:
            if (funct_legal(funct3, funct7)) begin Illegal_o = 1'b0; state_d = S_EXECI; end
          OP_BR:
            if (funct3[2:1] == 2'b00) begin Illegal_o = 1'b0; state_d = S_BRANCH; end
          OP_JAL:   begin Illegal_o = 1'b0; state_d = S_JAL; end
          OP_LUI:   begin Illegal_o = 1'b0; state_d = S_LUI; end
          OP_AUIPC: begin Illegal_o = 1'b0; state_d = S_AUIPC; end
          default: ;
        endcase
      end
      S_MEMADR: begin
        ALU_Src_A_o = SRCA_RS1;
        ALU_Src_B_o = SRCB_IMM;
        state_d     = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        Mem_Req_o = 1'b1;
        Adr_Src_o = 1'b1;
        if (Mem_Ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        Result_Src_o = RES_MDR;
        Reg_Write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        Mem_Req_o   = 1'b1;
        Mem_Write_o = 1'b1;
        Adr_Src_o   = 1'b1;
        if (Mem_Ready_i) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALU_Src_A_o   = SRCA_RS1;
        ALU_Control_o = alu_decode(funct3, funct7[5]);
        state_d       = S_ALUWB;
      end
      S_EXECI: begin
        ALU_Src_A_o   = SRCA_RS1;
        ALU_Src_B_o   = SRCB_IMM;
        ALU_Control_o = alu_decode(funct3, 1'b0);
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        Reg_Write_o = 1'b1;
        state_d     = S_FETCH;
      end
      // PC takes the target computed in DECODE while the ALU forms the link value.
      S_JAL: begin
        ALU_Src_A_o = SRCA_OLDPC;
        ALU_Src_B_o = SRCB_FOUR;
        PC_Write_o  = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BRANCH: begin
        ALU_Src_A_o   = SRCA_RS1;
        ALU_Control_o = ALU_SUB;
        PC_Write_o    = funct3[0] ? !Zero_i : Zero_i;
        state_d       = S_FETCH;
      end
      S_LUI: begin
        ALU_Src_A_o = SRCA_ZERO;
        ALU_Src_B_o = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_AUIPC: begin
        ALU_Src_A_o = SRCA_OLDPC;
        ALU_Src_B_o = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences the datapath immediately, even mid memory access.
    if (rst_i) begin
      Mem_Req_o     = 1'b0;
      Mem_Write_o   = 1'b0;
      Adr_Src_o     = 1'b0;
      IR_Write_o    = 1'b0;
      PC_Write_o    = 1'b0;
      Reg_Write_o   = 1'b0;
      Result_Src_o  = 2'b00;
      ALU_Src_A_o   = 2'b00;
      ALU_Src_B_o   = 2'b00;
      ALU_Control_o = 3'b000;
      Imm_Src_o     = 3'b000;
      Illegal_o     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

endmodule
